// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage with PC register, next-PC select
// (sequential / branch / jump / register jump), IF/ID pipeline register and a
// BOOT/RUN/HOLD control FSM. Redirects take priority over stalls and flush
// IF/ID with a bubble.
// Optional build macro FETCH_PERF_COUNTERS_EN adds the fetch_count and
// stall_count performance counters; without it both ports are tied to 0.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic [1:0]  pc_src,
  input  logic [31:0] branch_target,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_inst,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_e;

  localparam logic [1:0] SRC_SEQ    = 2'b00;
  localparam logic [1:0] SRC_BRANCH = 2'b01;
  localparam logic [1:0] SRC_JUMP   = 2'b10;
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic [31:0] pc4;
  logic [31:0] redirect_target;
  logic        redirect;

  // Sequential successor wraps naturally at 2^32; redirect targets are word-aligned.
  always_comb begin
    pc4      = pc_q + 32'd4;
    redirect = (pc_src != SRC_SEQ);
    case (pc_src)
      SRC_BRANCH: redirect_target = branch_target & WORD_MASK;
      SRC_JUMP:   redirect_target = {pc4[31:28], jump_index, 2'b00};
      default:    redirect_target = jr_target & WORD_MASK;
    endcase
  end

  // Next-state and IF/ID load decisions: redirect beats stall, stall holds.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    case (state_q)
      BOOT: state_d = RUN;
      RUN, HOLD: begin
        if (redirect) begin
          pc_d    = redirect_target;
          inst_d  = 32'd0;
          valid_d = 1'b0;
          state_d = RUN;
        end else if (stall) begin
          state_d = HOLD;
        end else begin
          pc_d    = pc4;
          inst_d  = imem_inst;
          pc4_d   = pc4;
          valid_d = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // PC, FSM state and IF/ID register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      pc4_q   <= 32'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign imem_addr   = pc_q;
  assign if_id_inst  = inst_q;
  assign if_id_pc4   = pc4_q;
  assign if_id_valid = valid_q;

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_count_q, stall_count_q;
  logic        accept;
  logic        in_hold;

  assign accept  = (state_q != BOOT) && !redirect && !stall;
  assign in_hold = (state_q == HOLD);

  // Performance counters: accepted fetches and cycles spent in HOLD, wrapping silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
    end else begin
      if (accept)  fetch_count_q <= fetch_count_q + 32'd1;
      if (in_hold) stall_count_q <= stall_count_q + 32'd1;
    end
  end

  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`else
  assign fetch_count = 32'd0;
  assign stall_count = 32'd0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed scenarios followed by random traffic,
// each cycle compared against a behavioural model of the fetch stage.
module tb_fetch_unit;

`ifdef FETCH_PERF_COUNTERS_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  pc_src = 2'b00;
  logic [31:0] branch_target = '0;
  logic [25:0] jump_index = '0;
  logic [31:0] jr_target = '0;
  logic [31:0] imem_addr, imem_inst;
  logic [31:0] if_id_inst, if_id_pc4;
  logic        if_id_valid;
  logic [31:0] fetch_count, stall_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model of the stage.
  logic [31:0] m_pc, m_inst, m_pc4, m_fetch, m_stall;
  logic        m_valid;
  bit          m_first;   // first cycle after reset release
  bit          m_stalled; // previous cycle stalled without redirect

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) + 32'h0000_1234;
  endfunction

  assign imem_inst = mem_word(imem_addr);

  fetch_unit dut (
    .clk(clk), .rst(rst), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .jump_index(jump_index), .jr_target(jr_target),
    .imem_addr(imem_addr), .imem_inst(imem_inst),
    .if_id_inst(if_id_inst), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string ctx);
    check({ctx, ".imem_addr"},   imem_addr,   m_pc);
    check({ctx, ".if_id_inst"},  if_id_inst,  m_inst);
    check({ctx, ".if_id_pc4"},   if_id_pc4,   m_pc4);
    check({ctx, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, m_valid});
    check({ctx, ".fetch_count"}, fetch_count, PERF ? m_fetch : 32'd0);
    check({ctx, ".stall_count"}, stall_count, PERF ? m_stall : 32'd0);
  endtask

  task automatic model_reset();
    m_pc = 32'd0; m_inst = 32'd0; m_pc4 = 32'd0; m_valid = 1'b0;
    m_fetch = 32'd0; m_stall = 32'd0; m_first = 1'b1; m_stalled = 1'b0;
  endtask

  // Async reset between edges; outputs must clear before any clock edge.
  task automatic do_reset(input string ctx);
    #3 rst = 1'b1;
    #1 model_reset();
    check_model({ctx, ".async"});
    @(posedge clk);
    #1 rst = 1'b0;
    check_model({ctx, ".held"});
  endtask

  // One clock: drive inputs, check combinational address, advance model, check after edge.
  task automatic cycle(input logic s, input logic [1:0] src, input logic [31:0] bt,
                       input logic [25:0] ji, input logic [31:0] jr, input string ctx);
    logic [31:0] seq;
    stall = s; pc_src = src; branch_target = bt; jump_index = ji; jr_target = jr;
    #1 check({ctx, ".pre_addr"}, imem_addr, m_pc);
    seq = m_pc + 32'd4;
    if (m_first) begin
      m_first = 1'b0;
    end else begin
      if (m_stalled) m_stall = m_stall + 32'd1;
      if (src != 2'b00) begin
        case (src)
          2'b01:   m_pc = bt - (bt % 4);
          2'b10:   m_pc = (seq & 32'hF000_0000) + ({6'd0, ji} * 4);
          default: m_pc = jr - (jr % 4);
        endcase
        m_inst = 32'd0; m_valid = 1'b0; m_stalled = 1'b0;
      end else if (s) begin
        m_stalled = 1'b1;
      end else begin
        m_inst = mem_word(m_pc); m_pc4 = seq; m_valid = 1'b1;
        m_pc = seq; m_fetch = m_fetch + 32'd1; m_stalled = 1'b0;
      end
    end
    @(posedge clk);
    #1 check_model(ctx);
  endtask

  task automatic seq_cycle(input string ctx);
    cycle(1'b0, 2'b00, 32'd0, 26'd0, 32'd0, ctx);
  endtask

  task automatic jr_cycle(input logic [31:0] t, input string ctx);
    cycle(1'b0, 2'b11, 32'd0, 26'd0, t, ctx);
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;

    // Reset state and boot sequence.
    do_reset("rst0");
    seq_cycle("boot");
    check("boot.addr", imem_addr, 32'd0);
    check("boot.valid", {31'd0, if_id_valid}, 32'd0);
    seq_cycle("first_fetch");
    check("first.pc4", if_id_pc4, 32'd4);
    check("first.valid", {31'd0, if_id_valid}, 32'd1);
    check("first.addr", imem_addr, 32'd4);

    // Branch from 0x40 with unaligned target.
    while (m_pc != 32'h40) seq_cycle("walk40");
    cycle(1'b0, 2'b01, 32'h103, 26'd0, 32'd0, "branch");
    check("branch.addr", imem_addr, 32'h100);
    check("branch.valid", {31'd0, if_id_valid}, 32'd0);
    seq_cycle("after_branch");
    check("after_branch.pc4", if_id_pc4, 32'h104);
    check("after_branch.valid", {31'd0, if_id_valid}, 32'd1);

    // J-format jump keeps the upper nibble of pc4.
    jr_cycle(32'h8000_0010, "jr_hi");
    cycle(1'b0, 2'b10, 32'd0, 26'h000_0040, 32'd0, "jump");
    check("jump.addr", imem_addr, 32'h8000_0100);

    // Three-cycle stall at 0x20 from a clean counter state.
    do_reset("rst1");
    seq_cycle("boot1");
    jr_cycle(32'h1C, "jr_1c");
    seq_cycle("fetch_1c");
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, "stall3");
      check("stall3.addr", imem_addr, 32'h20);
      check("stall3.pc4", if_id_pc4, 32'h20);
    end
    seq_cycle("release");
    check("release.pc4", if_id_pc4, 32'h24);
    check("release.stall_count", stall_count, PERF ? 32'd3 : 32'd0);

    // Redirect beats stall, from RUN and from HOLD.
    cycle(1'b1, 2'b11, 32'd0, 26'd0, 32'h200, "stall_jr_run");
    check("stall_jr_run.addr", imem_addr, 32'h200);
    check("stall_jr_run.valid", {31'd0, if_id_valid}, 32'd0);
    seq_cycle("refill");
    cycle(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, "enter_hold");
    cycle(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, "in_hold");
    cycle(1'b1, 2'b01, 32'h0000_0A02, 26'd0, 32'd0, "stall_br_hold");
    check("stall_br_hold.addr", imem_addr, 32'hA00);
    seq_cycle("post_hold");

    // Asynchronous reset during HOLD at 0x30.
    jr_cycle(32'h30, "jr_30");
    cycle(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, "hold30a");
    cycle(1'b1, 2'b11, 32'd0, 26'd0, 32'h30, "hold30_redirect");
    cycle(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, "hold30b");
    cycle(1'b1, 2'b00, 32'd0, 26'd0, 32'd0, "hold30c");
    do_reset("rst_hold");
    check("rst_hold.addr", imem_addr, 32'd0);
    check("rst_hold.fetch_count", fetch_count, 32'd0);
    check("rst_hold.stall_count", stall_count, 32'd0);
    stall = 1'b0; pc_src = 2'b00;
    seq_cycle("boot2");

    // PC wraps at the top of the address space.
    jr_cycle(32'hFFFF_FFFF, "jr_top");
    check("jr_top.addr", imem_addr, 32'hFFFF_FFFC);
    seq_cycle("wrap");
    check("wrap.addr", imem_addr, 32'd0);
    check("wrap.pc4", if_id_pc4, 32'd0);

    // Random traffic: mostly sequential, frequent stalls, occasional redirects.
    for (int i = 0; i < 400; i++) begin
      logic [1:0] src;
      src = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      cycle(1'($urandom_range(0, 2) == 0), src, $urandom, 26'($urandom), $urandom, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
